// File: rtl/r30_pkg.sv
// r30_pkg: shared Rule 30 FSM states and next-generation function
package r30_pkg;

    localparam int R30_MAXN = 1024;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} r30_fsm_t;

    // One Rule 30 step over the low n cells. Cells past either end read as 0.
    // Callers zero-extend narrower fields into the R30_MAXN-wide argument.
    function automatic logic [R30_MAXN-1:0] rule30_next(input logic [R30_MAXN-1:0] s, input int n);
        logic [R30_MAXN-1:0] m;
        m = (n >= R30_MAXN) ? '1 : (R30_MAXN'(1) << n) - R30_MAXN'(1);
        return ((s >> 1) ^ (s | (s << 1))) & m;
    endfunction

endpackage

// File: rtl/r30_step.sv
// r30_step: one combinational Rule 30 generation over N cells
module r30_step
    import r30_pkg::*;
#(
    parameter int N = 128
) (
    input  logic [N-1:0] cur,
    output logic [N-1:0] nxt
);

    assign nxt = N'(rule30_next(R30_MAXN'(cur), N));

endmodule

// File: rtl/r30_stream.sv
// r30_stream: clocked Rule 30 engine streaming the centre column as W-bit words
module r30_stream
    import r30_pkg::*;
#(
    parameter int N      = 128,
    parameter int D      = 256,
    parameter int W      = 32,
    parameter int CENTER = N / 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_valid,
    output logic         seed_ready,
    input  logic [N-1:0] seed,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [W-1:0] word,
    output logic [N-1:0] state,
    output logic         busy,
    output logic         done
);

    localparam int GW = $clog2(D + 1);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    r30_fsm_t      fsm;
    logic [GW-1:0] gen;
    logic [BW-1:0] bitcnt;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_n;
    logic [N-1:0]  nxt;
    logic          last_bit;

    r30_step #(.N(N)) u_step (.cur(state), .nxt(nxt));

    assign seed_ready = (fsm == IDLE || fsm == DONE) && !rst;
    assign last_bit   = (bitcnt == BW'(W - 1));

    // Accumulator with the current centre cell dropped into its LSB-first slot
    always_comb begin
        acc_n         = acc;
        acc_n[bitcnt] = state[CENTER];
    end

    // Seed load, per-cycle stepping, word hand-off and run completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            state      <= '0;
            word       <= '0;
            acc        <= '0;
            gen        <= '0;
            bitcnt     <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: if (seed_valid) begin
                    state  <= seed;
                    gen    <= '0;
                    bitcnt <= '0;
                    acc    <= '0;
                    done   <= 1'b0;
                    busy   <= 1'b1;
                    fsm    <= RUN;
                end
                RUN: begin
                    acc    <= acc_n;
                    state  <= nxt;
                    gen    <= gen + 1'b1;
                    bitcnt <= last_bit ? '0 : bitcnt + 1'b1;
                    if (last_bit) begin
                        word       <= acc_n;
                        word_valid <= 1'b1;
                        fsm        <= HOLD;
                    end
                end
                HOLD: if (word_ready) begin
                    word_valid <= 1'b0;
                    if (gen == GW'(D)) begin
                        fsm  <= DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        fsm <= RUN;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/r30_stream.md
# r30_stream

Sequential Rule 30 engine: accepts an N-cell seed, evolves it one generation per clock, and serialises the centre column into W-bit words over a valid/ready stream. It is the clocked consumer-side counterpart of the combinational `R30Field`. After D generations its `state` output equals `R30Field.final_state` for the same seed. It feeds downstream entropy consumers and lets the bench cross-check the combinational field.

## Interface
- `N`, 128, cell count.
- `D`, 256, generations per run; must be a multiple of W.
- `W`, 32, output word width.
- `CENTER`, N/2, index of the sampled cell.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `seed_valid`  in  1  seed offered.
- `seed_ready`  out  1  engine can accept a seed.
- `seed`  in  N  initial generation (generation 0).
- `word_valid`  out  1  `word` holds a complete packed word.
- `word_ready`  in  1  consumer accepts `word`.
- `word`  out  W  packed centre-column bits.
- `state`  out  N  current generation.
- `busy`  out  1  run in progress.
- `done`  out  1  D generations emitted; `state` holds generation D.

## Operation
- **Rule 30:** next[i] = L xor (C or R), where L = state[i+1], C = state[i] and R = state[i-1].
- **Boundaries:** cells outside 0..N-1 read as 0 (null boundary, same as `R30Field`).
- **FSM states:** IDLE, RUN, HOLD, DONE.
- **Seed acceptance:** `seed_ready` = (IDLE or DONE) and not rst. A handshake (`seed_valid` and `seed_ready`) at an edge loads `state` = `seed`, clears the generation counter, the bit counter and `done`, and moves to RUN.
- **RUN, each cycle:**
  - Shift `state[CENTER]` into the accumulator at position bitcnt. Packing is LSB first: word k bit j = centre cell of generation k*W+j.
  - `state` <= rule30(`state`); gen += 1.
  - When bitcnt reaches W-1: load `word` from the accumulator, assert `word_valid`, and go to HOLD.
- **HOLD:**
  - Stepping is frozen; `state` and `word` are stable.
  - On `word_valid` and `word_ready`: deassert `word_valid`. Go to DONE if gen == D, else to RUN.
- **DONE:** `done`=1, `busy`=0, `state` holds generation D. A new seed handshake restarts the run.
- **Counter widths:** gen is clog2(D+1) bits and never exceeds D. bitcnt is clog2(W) bits and wraps to 0 on each word.
- **Seed while busy:** `seed_valid` during RUN/HOLD is ignored (`seed_ready`=0).
- **Reset mid-run:** reset at any point aborts the run immediately. No partial word is emitted.

## Timing
- **Reset values:** `state`=0, `word`=0, `word_valid`=0, `busy`=0, `done`=0, FSM=IDLE. `seed_ready`=0 while rst is high and 1 from the first cycle after release.
- **Latency:** with the seed accepted at edge t, the first `word_valid` is high after edge t+W.
- **Throughput:** W+1 cycles per word with `word_ready` held high. Each extra stall cycle adds one.
- **Handshake rules:**
  - `word_valid`, once high, stays high and `word` stays stable until the handshake completes.
  - `word_ready` may toggle freely.
  - `word_valid` never depends combinationally on `word_ready`.
- **Run length:** `done` rises on the edge of the final (D/W-th) word handshake. A full run with no stalls takes D + D/W cycles after seed acceptance.
- **Outputs:** all outputs are registered except `seed_ready`.

## Structure
- **Package `r30_pkg`:** FSM state enum plus a `rule30_next` function, parameterised on N with the null boundary. `R30Field` uses the same function so both blocks share one definition.
- **Sub-module `r30_step`:** a single combinational generation (N in, N out). It is instantiated once in `r30_stream` and is reusable by `R30Field` as its per-layer cell.
- **Top:** FSM, counters and word register live in `r30_stream`.

## Test plan
- **Reset:** assert rst mid-cycle (asynchronous) -> all outputs 0 immediately; `seed_ready`=1 one cycle after release.
- **Single-seed words:** `seed`=1<<64 (N=128, D=256, W=32), `word_ready`=1 -> `word_valid` after 32 edges; `word[7:0]`=0x3B. All 8 words match the software Rule 30 centre-column model.
- **Equivalence:** same seed, run to `done` -> `state` == `R30Field(seed).final_state` (N=128, D=256). Repeat for 20 random seeds.
- **Backpressure:** hold `word_ready`=0 for 10 cycles on word 0 -> `word` and `state` frozen, gen unchanged. The stream resumes on release with identical words and total run time of 264 + 10 cycles.
- **Busy-time seed:** pulse `seed_valid` with a different seed during RUN -> ignored, output stream unchanged. After `done`, the new seed is accepted and `done` drops the next cycle.
- **Reset mid-run:** assert rst during HOLD of word 3 -> `word_valid`=0, `state`=0, FSM=IDLE. A subsequent seed produces a full fresh run.
